pipeline_ctrl: RTL and testbench

- Hazard and stall sequencer for the five-stage LC-3b pipeline.
- Drives the load-enable and bubble (flush) controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the PC load.
- Resolves memory-wait stalls, load-use hazards and taken-branch squashes.
- Keeps saturating performance counters for each event class.

---
 rtl/pipeline_ctrl.sv | 176 +++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Hazard/stall sequencer for the five-stage LC-3b pipe: combinational stage loads/flushes, registered state and counters.
// Zero-cycle control latency; a pending imem/dmem access freezes the whole pipe until its response arrives.
module pipeline_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             imem_req,
  input  logic             imem_resp,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  input  logic             ex_mem_read,
  input  logic [2:0]       ex_dest,
  input  logic [2:0]       id_sr1,
  input  logic [2:0]       id_sr2,
  input  logic             id_uses_sr1,
  input  logic             id_uses_sr2,
  input  logic             br_taken,
  output logic             load_pc,
  output logic             pc_sel_target,
  output logic             load_if_id,
  output logic             load_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] mem_stall_cnt,
  output logic [CNT_W-1:0] if_stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] squash_cnt
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    MEM_WAIT   = 2'd1,
    FETCH_WAIT = 2'd2,
    SQUASH     = 2'd3
  } state_e;

  state_e state_q, state_d;
  logic [CNT_W-1:0] mem_stall_cnt_q, mem_stall_cnt_d;
  logic [CNT_W-1:0] if_stall_cnt_q, if_stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;

  logic mem_busy, if_busy, hazard, in_squash;
  logic inc_mem, inc_if, inc_bubble, inc_squash;

  assign mem_busy  = dmem_req & ~dmem_resp;
  assign if_busy   = imem_req & ~imem_resp;
  assign hazard    = ex_mem_read &
                     ((id_uses_sr1 & (id_sr1 == ex_dest)) |
                      (id_uses_sr2 & (id_sr2 == ex_dest)));
  assign in_squash = (state_q == SQUASH);

  always_comb begin
    load_pc       = 1'b0;
    pc_sel_target = 1'b0;
    load_if_id    = 1'b0;
    load_id_ex    = 1'b0;
    load_ex_mem   = 1'b0;
    load_mem_wb   = 1'b0;
    flush_if_id   = 1'b0;
    flush_id_ex   = 1'b0;
    flush_ex_mem  = 1'b0;
    inc_mem       = 1'b0;
    inc_if        = 1'b0;
    inc_bubble    = 1'b0;
    inc_squash    = 1'b0;
    if (reset) begin
      flush_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
      flush_ex_mem = 1'b1;
    end else if (mem_busy) begin
      inc_mem = 1'b1;
    end else if (if_busy && !in_squash) begin
      inc_if = 1'b1;
    end else begin
      if (br_taken) begin
        load_pc       = 1'b1;
        pc_sel_target = 1'b1;
        load_if_id    = 1'b1;
        load_id_ex    = 1'b1;
        load_ex_mem   = 1'b1;
        load_mem_wb   = 1'b1;
        flush_if_id   = 1'b1;
        flush_id_ex   = 1'b1;
        flush_ex_mem  = 1'b1;
        inc_squash    = 1'b1;
      end else if (hazard) begin
        load_id_ex  = 1'b1;
        load_ex_mem = 1'b1;
        load_mem_wb = 1'b1;
        flush_id_ex = 1'b1;
        inc_bubble  = 1'b1;
      end else begin
        load_pc     = 1'b1;
        load_if_id  = 1'b1;
        load_id_ex  = 1'b1;
        load_ex_mem = 1'b1;
        load_mem_wb = 1'b1;
      end
      // Front end stays parked until the wrong-path fetch returns, then redirects and drops that word.
      if (in_squash) begin
        if (imem_resp) begin
          load_pc       = 1'b1;
          pc_sel_target = 1'b1;
          load_if_id    = 1'b1;
          flush_if_id   = 1'b1;
        end else begin
          load_pc    = 1'b0;
          load_if_id = 1'b0;
          inc_if     = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (mem_busy)                 state_d = MEM_WAIT;
        else if (if_busy && br_taken) state_d = SQUASH;
        else if (if_busy)             state_d = FETCH_WAIT;
      end
      MEM_WAIT: begin
        if (!mem_busy) state_d = if_busy ? FETCH_WAIT : RUN;
      end
      FETCH_WAIT: begin
        if (mem_busy)      state_d = MEM_WAIT;
        else if (!if_busy) state_d = RUN;
      end
      SQUASH: begin
        if (!mem_busy && imem_resp) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    mem_stall_cnt_d = mem_stall_cnt_q;
    if_stall_cnt_d  = if_stall_cnt_q;
    bubble_cnt_d    = bubble_cnt_q;
    squash_cnt_d    = squash_cnt_q;
    if (inc_mem && mem_stall_cnt_q != '1) mem_stall_cnt_d = mem_stall_cnt_q + CNT_W'(1);
    if (inc_if && if_stall_cnt_q != '1)   if_stall_cnt_d  = if_stall_cnt_q + CNT_W'(1);
    if (inc_bubble && bubble_cnt_q != '1) bubble_cnt_d    = bubble_cnt_q + CNT_W'(1);
    if (inc_squash && squash_cnt_q != '1) squash_cnt_d    = squash_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= RUN;
      mem_stall_cnt_q <= '0;
      if_stall_cnt_q  <= '0;
      bubble_cnt_q    <= '0;
      squash_cnt_q    <= '0;
    end else begin
      state_q         <= state_d;
      mem_stall_cnt_q <= mem_stall_cnt_d;
      if_stall_cnt_q  <= if_stall_cnt_d;
      bubble_cnt_q    <= bubble_cnt_d;
      squash_cnt_q    <= squash_cnt_d;
    end
  end

  assign state         = state_q;
  assign mem_stall_cnt = mem_stall_cnt_q;
  assign if_stall_cnt  = if_stall_cnt_q;
  assign bubble_cnt    = bubble_cnt_q;
  assign squash_cnt    = squash_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed, table-driven bench for pipeline_ctrl; a second CNT_W=4 instance shares the stimulus for saturation.
module tb_pipeline_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic imem_req, imem_resp, dmem_req, dmem_resp, ex_mem_read, br_taken;
  logic [2:0] ex_dest, id_sr1, id_sr2;
  logic id_uses_sr1, id_uses_sr2;

  logic load_pc, pc_sel_target, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic flush_if_id, flush_id_ex, flush_ex_mem;
  logic [1:0] state;
  logic [15:0] mem_stall_cnt, if_stall_cnt, bubble_cnt, squash_cnt;

  logic s_load_pc, s_pc_sel_target, s_load_if_id, s_load_id_ex, s_load_ex_mem, s_load_mem_wb;
  logic s_flush_if_id, s_flush_id_ex, s_flush_ex_mem;
  logic [1:0] s_state;
  logic [3:0] s_mem_stall_cnt, s_if_stall_cnt, s_bubble_cnt, s_squash_cnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pipeline_ctrl u_dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_resp(imem_resp), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .ex_mem_read(ex_mem_read), .ex_dest(ex_dest), .id_sr1(id_sr1), .id_sr2(id_sr2),
    .id_uses_sr1(id_uses_sr1), .id_uses_sr2(id_uses_sr2), .br_taken(br_taken),
    .load_pc(load_pc), .pc_sel_target(pc_sel_target), .load_if_id(load_if_id),
    .load_id_ex(load_id_ex), .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
    .state(state), .mem_stall_cnt(mem_stall_cnt), .if_stall_cnt(if_stall_cnt),
    .bubble_cnt(bubble_cnt), .squash_cnt(squash_cnt)
  );

  pipeline_ctrl #(.CNT_W(4)) u_sat (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_resp(imem_resp), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .ex_mem_read(ex_mem_read), .ex_dest(ex_dest), .id_sr1(id_sr1), .id_sr2(id_sr2),
    .id_uses_sr1(id_uses_sr1), .id_uses_sr2(id_uses_sr2), .br_taken(br_taken),
    .load_pc(s_load_pc), .pc_sel_target(s_pc_sel_target), .load_if_id(s_load_if_id),
    .load_id_ex(s_load_id_ex), .load_ex_mem(s_load_ex_mem), .load_mem_wb(s_load_mem_wb),
    .flush_if_id(s_flush_if_id), .flush_id_ex(s_flush_id_ex), .flush_ex_mem(s_flush_ex_mem),
    .state(s_state), .mem_stall_cnt(s_mem_stall_cnt), .if_stall_cnt(s_if_stall_cnt),
    .bubble_cnt(s_bubble_cnt), .squash_cnt(s_squash_cnt)
  );

  // {load_pc, pc_sel_target, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, flush_if_id, flush_id_ex, flush_ex_mem}
  localparam logic [8:0] C_NORM = 9'b1_0_1111_000;
  localparam logic [8:0] C_FRZ  = 9'b0_0_0000_000;
  localparam logic [8:0] C_BR   = 9'b1_1_1111_111;
  localparam logic [8:0] C_HAZ  = 9'b0_0_0111_010;
  localparam logic [8:0] C_SQW  = 9'b0_0_0111_000;
  localparam logic [8:0] C_SQB  = 9'b0_1_0111_111;
  localparam logic [8:0] C_SQR  = 9'b1_1_1111_100;
  localparam logic [8:0] C_RST  = 9'b0_0_0000_111;

  localparam logic [1:0] S_RUN = 2'd0, S_MW = 2'd1, S_FW = 2'd2, S_SQ = 2'd3;

  typedef struct {
    logic       ir, irs, dr, drs, exr;
    logic [2:0] exd, s1, s2;
    logic       u1, u2, br;
    logic [8:0] ctl;
    logic [1:0] st;
    logic [15:0] m, i, b, s;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic ir, input logic irs, input logic dr, input logic drs,
                              input logic exr, input logic [2:0] exd, input logic [2:0] s1,
                              input logic [2:0] s2, input logic u1, input logic u2, input logic br,
                              input logic [8:0] ctl, input logic [1:0] st,
                              input int m, input int i, input int b, input int s);
    vec_t v;
    v.ir = ir; v.irs = irs; v.dr = dr; v.drs = drs; v.exr = exr;
    v.exd = exd; v.s1 = s1; v.s2 = s2; v.u1 = u1; v.u2 = u2; v.br = br;
    v.ctl = ctl; v.st = st;
    v.m = 16'(m); v.i = 16'(i); v.b = 16'(b); v.s = 16'(s);
    return v;
  endfunction

  function automatic logic [8:0] ctl_main();
    return {load_pc, pc_sel_target, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
            flush_if_id, flush_id_ex, flush_ex_mem};
  endfunction

  function automatic logic [8:0] ctl_sat();
    return {s_load_pc, s_pc_sel_target, s_load_if_id, s_load_id_ex, s_load_ex_mem, s_load_mem_wb,
            s_flush_if_id, s_flush_id_ex, s_flush_ex_mem};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    imem_req = v.ir; imem_resp = v.irs; dmem_req = v.dr; dmem_resp = v.drs;
    ex_mem_read = v.exr; ex_dest = v.exd; id_sr1 = v.s1; id_sr2 = v.s2;
    id_uses_sr1 = v.u1; id_uses_sr2 = v.u2; br_taken = v.br;
  endtask

  initial begin
    vec_t v;
    // Same-cycle imem/dmem responses: 0-wait accesses.
    for (int k = 0; k < 10; k++)
      tv.push_back(mk(1,1,1,1, 0,0,0,0,0,0,0, C_NORM, S_RUN, 0,0,0,0));
    // dmem stall, response on 4th cycle
    tv.push_back(mk(1,1,1,0, 0,0,0,0,0,0,0, C_FRZ,  S_MW,  1,0,0,0));
    tv.push_back(mk(1,1,1,0, 0,0,0,0,0,0,0, C_FRZ,  S_MW,  2,0,0,0));
    tv.push_back(mk(1,1,1,0, 0,0,0,0,0,0,0, C_FRZ,  S_MW,  3,0,0,0));
    tv.push_back(mk(1,1,1,1, 0,0,0,0,0,0,0, C_NORM, S_RUN, 3,0,0,0));
    tv.push_back(mk(1,1,1,1, 0,0,0,0,0,0,0, C_NORM, S_RUN, 3,0,0,0));
    // load-use on SR2, then unused-source and SR1 variants
    tv.push_back(mk(1,1,1,1, 1,3,5,3,1,1,0, C_HAZ,  S_RUN, 3,0,1,0));
    tv.push_back(mk(1,1,1,1, 0,3,5,3,1,1,0, C_NORM, S_RUN, 3,0,1,0));
    tv.push_back(mk(1,1,1,1, 1,3,3,3,0,0,0, C_NORM, S_RUN, 3,0,1,0));
    tv.push_back(mk(1,1,1,1, 1,6,6,0,1,0,0, C_HAZ,  S_RUN, 3,0,2,0));
    tv.push_back(mk(1,1,1,1, 0,6,6,0,1,0,0, C_NORM, S_RUN, 3,0,2,0));
    // hazard and branch together: branch wins
    tv.push_back(mk(1,1,1,1, 1,3,0,3,0,1,1, C_BR,   S_RUN, 3,0,2,1));
    tv.push_back(mk(1,1,1,1, 0,0,0,0,0,0,0, C_NORM, S_RUN, 3,0,2,1));
    // branch during outstanding fetch -> SQUASH, redirect on imem_resp
    tv.push_back(mk(1,0,1,1, 0,0,0,0,0,0,1, C_FRZ,  S_SQ,  3,1,2,1));
    tv.push_back(mk(1,0,1,1, 0,0,0,0,0,0,1, C_SQB,  S_SQ,  3,2,2,2));
    tv.push_back(mk(1,0,1,1, 0,0,0,0,0,0,0, C_SQW,  S_SQ,  3,3,2,2));
    tv.push_back(mk(1,1,1,1, 0,0,0,0,0,0,0, C_SQR,  S_RUN, 3,3,2,2));
    tv.push_back(mk(1,1,1,1, 0,0,0,0,0,0,0, C_NORM, S_RUN, 3,3,2,2));
    // FETCH_WAIT <-> MEM_WAIT interplay
    tv.push_back(mk(1,0,1,1, 0,0,0,0,0,0,0, C_FRZ,  S_FW,  3,4,2,2));
    tv.push_back(mk(1,0,1,0, 0,0,0,0,0,0,0, C_FRZ,  S_MW,  4,4,2,2));
    tv.push_back(mk(1,0,1,1, 0,0,0,0,0,0,0, C_FRZ,  S_FW,  4,5,2,2));
    tv.push_back(mk(1,1,1,1, 0,0,0,0,0,0,0, C_NORM, S_RUN, 4,5,2,2));

    reset = 1'b1;
    drive(mk(0,0,0,0, 0,0,0,0,0,0,0, C_RST, S_RUN, 0,0,0,0));
    #2;
    chk("reset ctl", 64'(ctl_main()), 64'(C_RST));
    chk("reset state", 64'(state), 64'(S_RUN));
    chk("reset cnts", {mem_stall_cnt, if_stall_cnt, bubble_cnt, squash_cnt}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < tv.size(); k++) begin
      drive(tv[k]);
      #2;
      chk($sformatf("row%0d ctl", k), 64'(ctl_main()), 64'(tv[k].ctl));
      @(posedge clk);
      #1;
      chk($sformatf("row%0d state", k), 64'(state), 64'(tv[k].st));
      chk($sformatf("row%0d cnts", k), {mem_stall_cnt, if_stall_cnt, bubble_cnt, squash_cnt},
          {tv[k].m, tv[k].i, tv[k].b, tv[k].s});
      @(negedge clk);
    end

    // 20 dmem stall cycles: the 4-bit counter must pin at 15
    v = mk(1,1,1,0, 0,0,0,0,0,0,0, C_FRZ, S_MW, 0,0,0,0);
    drive(v);
    for (int k = 0; k < 20; k++) begin
      #2;
      chk($sformatf("sat%0d ctl", k), 64'(ctl_sat()), 64'(C_FRZ));
      @(posedge clk);
      #1;
      chk($sformatf("sat%0d mem16", k), 64'(mem_stall_cnt), 64'(5 + k));
      chk($sformatf("sat%0d mem4", k), 64'(s_mem_stall_cnt), 64'((5 + k > 15) ? 15 : 5 + k));
      @(negedge clk);
    end
    chk("sat state", 64'(s_state), 64'(S_MW));
    chk("sat other cnts", {s_if_stall_cnt, s_bubble_cnt, s_squash_cnt}, {4'd5, 4'd2, 4'd2});

    // asynchronous reset in the middle of MEM_WAIT
    #3;
    reset = 1'b1;
    #1;
    chk("arst state", 64'(state), 64'(S_RUN));
    chk("arst ctl", 64'(ctl_main()), 64'(C_RST));
    chk("arst cnts16", {mem_stall_cnt, if_stall_cnt, bubble_cnt, squash_cnt}, 64'd0);
    chk("arst cnts4", {s_mem_stall_cnt, s_if_stall_cnt, s_bubble_cnt, s_squash_cnt}, 64'd0);
    @(posedge clk);
    #1;
    chk("arst hold state", 64'(state), 64'(S_RUN));
    chk("arst hold ctl", 64'(ctl_sat()), 64'(C_RST));
    @(negedge clk);
    reset = 1'b0;
    drive(mk(1,1,1,1, 0,0,0,0,0,0,0, C_NORM, S_RUN, 0,0,0,0));
    #2;
    chk("post-reset ctl", 64'(ctl_main()), 64'(C_NORM));
    @(posedge clk);
    #1;
    chk("post-reset state", 64'(state), 64'(S_RUN));
    chk("post-reset cnts", {mem_stall_cnt, if_stall_cnt, bubble_cnt, squash_cnt}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
